// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: controller state encoding,
// HTRANS codes and the peripheral address map behind the tempselx decode.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WWAIT   = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RENABLE = 3'd4,
        ST_WENABLE = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int unsigned NUM_PERIPH = 3;
    localparam logic [31:0] PERIPH_SIZE = 32'h0400_0000;
    localparam logic [31:0] PERIPH_BASE [NUM_PERIPH] = '{
        32'h8000_0000,
        32'h8400_0000,
        32'h8800_0000
    };

    // One-hot select for an address; all-zero means no peripheral is mapped there.
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        for (int i = 0; i < int'(NUM_PERIPH); i++) begin
            if (addr >= PERIPH_BASE[i] && (addr - PERIPH_BASE[i]) < PERIPH_SIZE) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_controller.sv
// APB sequencing stage of the AHB-to-APB bridge: turns one qualified AHB transfer
// into an APB SETUP/ENABLE pair and stalls the AHB master through hreadyout.
module apb_controller
    import bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [2:0]        tempselx,
    output logic [2:0]        pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        sel_q, sel_d;

    logic [2:0]        pselx_d;
    logic              penable_d;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              hreadyout_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            pselx     <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            hreadyout <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            pselx     <= pselx_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            hreadyout <= hreadyout_d;
        end
    end

    // Outputs are loaded with the values of the state being entered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        pselx_d     = pselx;
        penable_d   = penable;
        pwrite_d    = pwrite;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        hreadyout_d = hreadyout;

        unique case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite) begin
                    state_d     = ST_READ;
                    paddr_d     = haddr;
                    pselx_d     = tempselx;
                    pwrite_d    = 1'b0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end else if (valid && hwrite) begin
                    // Write data arrives one cycle after the address phase.
                    state_d     = ST_WWAIT;
                    addr_d      = haddr;
                    sel_d       = tempselx;
                    pselx_d     = 3'b000;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end else begin
                    state_d     = ST_IDLE;
                    pselx_d     = 3'b000;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    hreadyout_d = 1'b1;
                end
            end
            ST_WWAIT: begin
                state_d     = ST_WRITE;
                paddr_d     = addr_q;
                pselx_d     = sel_q;
                pwdata_d    = hwdata;
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_READ: begin
                state_d     = ST_RENABLE;
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            ST_WRITE: begin
                state_d     = ST_WENABLE;
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                pselx_d     = 3'b000;
                penable_d   = 1'b0;
                pwrite_d    = 1'b0;
                hreadyout_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_controller.sv
// Scoreboard bench for apb_controller: the driver queues each accepted transfer,
// the monitor derives the expected APB phase from the transfer's age each cycle.
module tb_apb_controller;
    import bridge_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic              valid;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic [2:0]        tempselx;
    logic [2:0]        pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              hreadyout;

    apb_controller #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .valid    (valid),
        .hwrite   (hwrite),
        .haddr    (haddr),
        .hwdata   (hwdata),
        .tempselx (tempselx),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .hreadyout(hreadyout)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [2:0]  sel;
        logic [31:0] data;
        int          acc;
    } xfer_t;

    xfer_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    bit    mon_en = 1'b0;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a transfer accepted in cycle a is in WWAIT/SETUP/ENABLE at a+1.. by kind.
    initial begin : monitor
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        xfer_t       t;
        int          p;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                exp_q.delete();
                m_addr  = 32'h0;
                m_wdata = 32'h0;
            end else if (mon_en) begin
                if (exp_q.size() > 0 && cyc - exp_q[0].acc >= 1) begin
                    t = exp_q[0];
                    p = cyc - t.acc;
                    if (!t.w) begin
                        m_addr = t.addr;
                        check("rd_pselx", 64'(pselx), 64'(t.sel));
                        check("rd_paddr", 64'(paddr), 64'(t.addr));
                        check("rd_pwrite", 64'(pwrite), 64'd0);
                        check("rd_pwdata_kept", 64'(pwdata), 64'(m_wdata));
                        check("rd_penable", 64'(penable), 64'(p >= 2));
                        check("rd_hreadyout", 64'(hreadyout), 64'(p >= 2));
                        if (p >= 2) void'(exp_q.pop_front());
                    end else if (p == 1) begin
                        check("ww_pselx", 64'(pselx), 64'd0);
                        check("ww_penable", 64'(penable), 64'd0);
                        check("ww_hreadyout", 64'(hreadyout), 64'd0);
                        check("ww_paddr_kept", 64'(paddr), 64'(m_addr));
                    end else begin
                        m_addr  = t.addr;
                        m_wdata = t.data;
                        check("wr_pselx", 64'(pselx), 64'(t.sel));
                        check("wr_paddr", 64'(paddr), 64'(t.addr));
                        check("wr_pwrite", 64'(pwrite), 64'd1);
                        check("wr_pwdata", 64'(pwdata), 64'(t.data));
                        check("wr_penable", 64'(penable), 64'(p >= 3));
                        check("wr_hreadyout", 64'(hreadyout), 64'(p >= 3));
                        if (p >= 3) void'(exp_q.pop_front());
                    end
                end else begin
                    check("idle_pselx", 64'(pselx), 64'd0);
                    check("idle_penable", 64'(penable), 64'd0);
                    check("idle_pwrite", 64'(pwrite), 64'd0);
                    check("idle_hreadyout", 64'(hreadyout), 64'd1);
                    check("idle_paddr_kept", 64'(paddr), 64'(m_addr));
                    check("idle_pwdata_kept", 64'(pwdata), 64'(m_wdata));
                end
            end
        end
    end

    // Called at posedge+1; waits for hreadyout, presents one address phase, returns
    // at the next posedge+1 with the write data phase (if any) driven.
    task automatic issue(input logic w, input logic [31:0] addr, input logic [2:0] sel,
                         input logic [31:0] data);
        xfer_t t;
        int    n;
        n = 0;
        while (hreadyout !== 1'b1 && n < 50) begin
            valid = 1'b0;
            @(posedge hclk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check("hreadyout_timeout", 64'(hreadyout), 64'd1);
        end
        valid    = 1'b1;
        hwrite   = w;
        haddr    = addr;
        tempselx = sel;
        if (w) hwdata = $urandom;
        t.w    = w;
        t.addr = addr;
        t.sel  = sel;
        t.data = data;
        t.acc  = cyc;
        exp_q.push_back(t);
        @(posedge hclk);
        #1;
        valid    = 1'b0;
        hwrite   = 1'($urandom);
        haddr    = $urandom;
        tempselx = 3'($urandom);
        if (w) hwdata = data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            valid = 1'b0;
            @(posedge hclk);
            #1;
        end
    endtask

    initial begin : stimulus
        logic [31:0] a;
        int          idx;
        hresetn  = 1'b0;
        valid    = 1'b0;
        hwrite   = 1'b0;
        haddr    = '0;
        hwdata   = '0;
        tempselx = 3'b000;
        #8;
        check("rst_hreadyout", 64'(hreadyout), 64'd1);
        check("rst_pselx", 64'(pselx), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        #2 hresetn = 1'b1;
        #1 mon_en = 1'b1;
        @(posedge hclk);
        #1;

        issue(1'b1, 32'h8000_0010, 3'b001, 32'h1234_5678);
        idle(3);
        issue(1'b0, 32'h8400_0020, 3'b010, 32'h0);
        idle(3);
        // Read chained straight into a write, then a write chained into a read.
        issue(1'b0, 32'h8400_0044, 3'b010, 32'h0);
        issue(1'b1, 32'h8800_0008, 3'b100, 32'hCAFE_F00D);
        issue(1'b0, 32'h8000_0100, 3'b001, 32'h0);
        idle(3);
        issue(1'b0, 32'h7000_0000, 3'b000, 32'h0);
        issue(1'b1, 32'h7000_0004, 3'b000, 32'hDEAD_BEEF);
        idle(3);

        for (int i = 0; i < 120; i++) begin
            idx = $urandom_range(0, 3);
            if (idx < 3) a = PERIPH_BASE[idx] + ($urandom & 32'h03FF_FFFC);
            else         a = 32'h7000_0000 + ($urandom & 32'h00FF_FFFC);
            issue(1'($urandom), a, decode_sel(a), $urandom);
            idle($urandom_range(0, 2));
        end
        idle(4);

        // Reset asserted while the write is in its SETUP cycle.
        issue(1'b1, 32'h8400_0080, 3'b010, 32'h5555_AAAA);
        @(posedge hclk);
        #1;
        check("pre_rst_pwrite", 64'(pwrite), 64'd1);
        #1 hresetn = 1'b0;
        #1;
        check("midrst_pselx", 64'(pselx), 64'd0);
        check("midrst_penable", 64'(penable), 64'd0);
        check("midrst_pwrite", 64'(pwrite), 64'd0);
        check("midrst_paddr", 64'(paddr), 64'd0);
        check("midrst_pwdata", 64'(pwdata), 64'd0);
        check("midrst_hreadyout", 64'(hreadyout), 64'd1);
        @(posedge hclk);
        @(posedge hclk);
        #3 hresetn = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
